// File: rtl/ahb_mtx_dec_param_if.sv
// Input-stage and output-stage bus signals of one L1 matrix decoder.
// The slave modport is the decoder's view; master is the driving side.
interface ahb_mtx_dec_param_if #(
  parameter int NUM_PORTS = 4,
  parameter int DW        = 22
);
  logic                      HREADYS;
  logic                      sel_dec;
  logic [DW-1:0]             decode_addr_dec;
  logic [1:0]                trans_dec;
  logic [NUM_PORTS-1:0]      active_i;
  logic [NUM_PORTS-1:0]      readyout_i;
  logic [2*NUM_PORTS-1:0]    resp_i;
  logic [32*NUM_PORTS-1:0]   rdata_i;
  logic [NUM_PORTS-1:0]      sel_o;
  logic                      active_dec;
  logic                      HREADYOUTS;
  logic [1:0]                HRESPS;
  logic [31:0]               HRDATAS;

  modport slave (
    input  HREADYS, sel_dec, decode_addr_dec, trans_dec,
           active_i, readyout_i, resp_i, rdata_i,
    output sel_o, active_dec, HREADYOUTS, HRESPS, HRDATAS
  );

  modport master (
    output HREADYS, sel_dec, decode_addr_dec, trans_dec,
           active_i, readyout_i, resp_i, rdata_i,
    input  sel_o, active_dec, HREADYOUTS, HRESPS, HRDATAS
  );
endinterface

// File: rtl/ahb_mtx_dec_param.sv
// Parametrised AHB matrix input-stage decoder with integrated default slave
// and sticky capture of unmapped accesses for debug.
module ahb_mtx_dec_param #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_LO   = 10,
  localparam int DW       = 32 - ADDR_LO,
  parameter logic [NUM_PORTS*DW-1:0] REGION_BASE  = '0,
  parameter logic [NUM_PORTS*DW-1:0] REGION_LIMIT = '0,
  parameter logic [NUM_PORTS-1:0]    PORT_EN      = '1
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  ahb_mtx_dec_param_if.slave   bus,
  input  logic                 err_clr,
  output logic                 err_valid_o,
  output logic [DW-1:0]        err_addr_o,
  output logic [7:0]           err_count_o
);

  localparam int PW = $clog2(NUM_PORTS + 2);
  localparam logic [PW-1:0] DFT  = PW'(NUM_PORTS);
  localparam logic [PW-1:0] NONE = PW'(NUM_PORTS + 1);
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {DFT_IDLE, DFT_ERR1, DFT_ERR2} dft_state_t;

  dft_state_t      dft_state;
  logic            dft_ready;
  logic [1:0]      dft_resp;
  logic [PW-1:0]   addr_port;
  logic [PW-1:0]   data_port;
  logic            sel_dft;
  logic            acc;

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    addr_port = DFT;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (PORT_EN[i] &&
          bus.decode_addr_dec >= REGION_BASE[i*DW +: DW] &&
          bus.decode_addr_dec <= REGION_LIMIT[i*DW +: DW])
        addr_port = PW'(i);
    end
    if (data_port < DFT && bus.trans_dec == 2'b00)
      addr_port = data_port;
  end

  always_comb begin
    bus.sel_o      = '0;
    bus.active_dec = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_port == PW'(i)) begin
        bus.sel_o[i]   = bus.sel_dec;
        bus.active_dec = bus.active_i[i];
      end
    end
  end

  assign sel_dft = bus.sel_dec && (addr_port == DFT);
  assign acc     = sel_dft && bus.HREADYS && bus.trans_dec[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      data_port <= NONE;
    else if (bus.HREADYS)
      data_port <= addr_port;
  end

  always_comb begin
    bus.HREADYOUTS = 1'b1;
    bus.HRESPS     = RESP_OKAY;
    bus.HRDATAS    = '0;
    if (data_port == DFT) begin
      bus.HREADYOUTS = dft_ready;
      bus.HRESPS     = dft_resp;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (data_port == PW'(i)) begin
        bus.HREADYOUTS = bus.readyout_i[i];
        bus.HRESPS     = bus.resp_i[2*i +: 2];
        bus.HRDATAS    = bus.rdata_i[32*i +: 32];
      end
    end
  end

  // Two-cycle ERROR response: wait state first, then the completing cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dft_state <= DFT_IDLE;
      dft_ready <= 1'b1;
      dft_resp  <= RESP_OKAY;
    end else begin
      case (dft_state)
        DFT_ERR1: begin
          dft_state <= DFT_ERR2;
          dft_ready <= 1'b1;
          dft_resp  <= RESP_ERROR;
        end
        default: begin
          if (acc) begin
            dft_state <= DFT_ERR1;
            dft_ready <= 1'b0;
            dft_resp  <= RESP_ERROR;
          end else begin
            dft_state <= DFT_IDLE;
            dft_ready <= 1'b1;
            dft_resp  <= RESP_OKAY;
          end
        end
      endcase
    end
  end

  // A clear coinciding with an accept restarts capture from that access.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
      err_count_o <= '0;
    end else if (err_clr) begin
      err_valid_o <= acc;
      err_count_o <= acc ? 8'd1 : 8'd0;
      if (acc)
        err_addr_o <= bus.decode_addr_dec;
    end else if (acc) begin
      if (err_count_o != 8'hFF)
        err_count_o <= err_count_o + 8'd1;
      if (!err_valid_o) begin
        err_valid_o <= 1'b1;
        err_addr_o  <= bus.decode_addr_dec;
      end
    end
  end

endmodule

// File: tb/tb_ahb_mtx_dec_param.sv
// Directed bench for ahb_mtx_dec_param: a fully connected 3-port instance
// plus a second instance with port 1 disconnected, fed the same stimulus.
module tb_ahb_mtx_dec_param;
  localparam int NP = 3;
  localparam int DW = 22;
  localparam logic [NP*DW-1:0] BASE  = {22'h140000, 22'h180000, 22'h080000};
  localparam logic [NP*DW-1:0] LIMIT = {22'h17FFFF, 22'h27FFFF, 22'h08003F};

  logic HCLK = 1'b0;
  logic HRESETn;
  logic err_clr;
  logic err_valid, err_valid2;
  logic [DW-1:0] err_addr, err_addr2;
  logic [7:0] err_count, err_count2;

  int vectors = 0;
  int miscompares = 0;
  int sel1_seen = 0;

  ahb_mtx_dec_param_if #(.NUM_PORTS(NP), .DW(DW)) bus ();
  ahb_mtx_dec_param_if #(.NUM_PORTS(NP), .DW(DW)) bus2 ();

  ahb_mtx_dec_param #(.NUM_PORTS(NP), .ADDR_LO(10), .REGION_BASE(BASE),
                      .REGION_LIMIT(LIMIT), .PORT_EN(3'b111)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus), .err_clr(err_clr),
    .err_valid_o(err_valid), .err_addr_o(err_addr), .err_count_o(err_count)
  );

  ahb_mtx_dec_param #(.NUM_PORTS(NP), .ADDR_LO(10), .REGION_BASE(BASE),
                      .REGION_LIMIT(LIMIT), .PORT_EN(3'b101)) dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus2), .err_clr(err_clr),
    .err_valid_o(err_valid2), .err_addr_o(err_addr2), .err_count_o(err_count2)
  );

  always #5 HCLK = ~HCLK;

  // Each decoder sees its own ready fed back, as the input stage would.
  assign bus.HREADYS          = bus.HREADYOUTS;
  assign bus2.HREADYS         = bus2.HREADYOUTS;
  assign bus2.sel_dec         = bus.sel_dec;
  assign bus2.decode_addr_dec = bus.decode_addr_dec;
  assign bus2.trans_dec       = bus.trans_dec;
  assign bus2.active_i        = bus.active_i;
  assign bus2.readyout_i      = bus.readyout_i;
  assign bus2.resp_i          = bus.resp_i;
  assign bus2.rdata_i         = bus.rdata_i;

  always @(negedge HCLK)
    if (bus2.sel_o[1] === 1'b1) sel1_seen++;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] a,
                               input logic [1:0] t, input logic clr);
    bus.sel_dec         = s;
    bus.decode_addr_dec = a[31:10];
    bus.trans_dec       = t;
    err_clr             = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn = 1'b0;
    bus.active_i   = 3'b101;
    bus.readyout_i = 3'b111;
    bus.resp_i     = '0;
    bus.rdata_i    = {32'h22222222, 32'h11111111, 32'hCAFEF00D};
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    #1;
    checkOutput("reset sel_o", 64'(bus.sel_o), 64'h0);
    checkOutput("reset ready", 64'(bus.HREADYOUTS), 64'h1);
    checkOutput("reset resp", 64'(bus.HRESPS), 64'h0);
    checkOutput("reset rdata", 64'(bus.HRDATAS), 64'h0);
    checkOutput("reset count", 64'(err_count), 64'h0);
    checkOutput("reset valid", 64'(err_valid), 64'h0);

    applyStimulus(1'b1, 32'h20000100, 2'b10, 1'b0);
    checkOutput("p0 sel_o", 64'(bus.sel_o), 64'h1);
    checkOutput("p0 active", 64'(bus.active_dec), 64'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    checkOutput("p0 rdata", 64'(bus.HRDATAS), 64'hCAFEF00D);
    checkOutput("p0 ready", 64'(bus.HREADYOUTS), 64'h1);
    tick();

    applyStimulus(1'b1, 32'h60000000, 2'b10, 1'b0);
    checkOutput("p1 sel_o", 64'(bus.sel_o), 64'h2);
    checkOutput("p1 active", 64'(bus.active_dec), 64'h0);
    tick();
    applyStimulus(1'b1, 32'h40000000, 2'b00, 1'b0);
    checkOutput("hold sel_o", 64'(bus.sel_o), 64'h2);
    checkOutput("p1 rdata", 64'(bus.HRDATAS), 64'h11111111);
    tick();
    checkOutput("hold resp", 64'(bus.HRESPS), 64'h0);
    checkOutput("hold ready", 64'(bus.HREADYOUTS), 64'h1);
    checkOutput("hold count", 64'(err_count), 64'h0);

    applyStimulus(1'b1, 32'h00000000, 2'b10, 1'b0);
    checkOutput("dft sel_o", 64'(bus.sel_o), 64'h0);
    checkOutput("dft active", 64'(bus.active_dec), 64'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    checkOutput("err1 ready", 64'(bus.HREADYOUTS), 64'h0);
    checkOutput("err1 resp", 64'(bus.HRESPS), 64'h1);
    checkOutput("err1 rdata", 64'(bus.HRDATAS), 64'h0);
    checkOutput("err valid", 64'(err_valid), 64'h1);
    checkOutput("err addr", 64'(err_addr), 64'h0);
    checkOutput("err count", 64'(err_count), 64'h1);
    tick();
    checkOutput("err2 ready", 64'(bus.HREADYOUTS), 64'h1);
    checkOutput("err2 resp", 64'(bus.HRESPS), 64'h1);
    tick();
    checkOutput("dft idle resp", 64'(bus.HRESPS), 64'h0);

    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    checkOutput("clr valid", 64'(err_valid), 64'h0);
    checkOutput("clr count", 64'(err_count), 64'h0);
    checkOutput("clr addr held", 64'(err_addr), 64'h0);

    applyStimulus(1'b1, 32'h30000000, 2'b10, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h30000400, 2'b10, 1'b0);
    checkOutput("b2b err1a ready", 64'(bus.HREADYOUTS), 64'h0);
    tick();
    checkOutput("b2b err2a ready", 64'(bus.HREADYOUTS), 64'h1);
    checkOutput("b2b err2a resp", 64'(bus.HRESPS), 64'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    checkOutput("b2b err1b ready", 64'(bus.HREADYOUTS), 64'h0);
    checkOutput("b2b err1b resp", 64'(bus.HRESPS), 64'h1);
    checkOutput("b2b addr", 64'(err_addr), 64'h0C0000);
    checkOutput("b2b count", 64'(err_count), 64'h2);
    tick();
    checkOutput("b2b err2b resp", 64'(bus.HRESPS), 64'h1);
    tick();

    applyStimulus(1'b1, 32'h30000000, 2'b10, 1'b0);
    for (int i = 0; i < 200; i++) tick();
    checkOutput("count mid", 64'(err_count), 64'd102);
    for (int i = 0; i < 400; i++) tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    tick();
    checkOutput("count sat", 64'(err_count), 64'd255);

    applyStimulus(1'b1, 32'h30000800, 2'b10, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    checkOutput("clr+acc valid", 64'(err_valid), 64'h1);
    checkOutput("clr+acc count", 64'(err_count), 64'h1);
    checkOutput("clr+acc addr", 64'(err_addr), 64'h0C0002);
    tick();
    tick();

    applyStimulus(1'b1, 32'h00000000, 2'b10, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    HRESETn = 1'b0;
    #1;
    checkOutput("mid rst ready", 64'(bus.HREADYOUTS), 64'h1);
    checkOutput("mid rst resp", 64'(bus.HRESPS), 64'h0);
    checkOutput("mid rst count", 64'(err_count), 64'h0);
    checkOutput("mid rst valid", 64'(err_valid), 64'h0);
    tick();
    HRESETn = 1'b1;
    tick();

    applyStimulus(1'b1, 32'h60000000, 2'b10, 1'b0);
    checkOutput("sparse sel_o", 64'(bus2.sel_o), 64'h0);
    checkOutput("sparse active", 64'(bus2.active_dec), 64'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    checkOutput("sparse ready", 64'(bus2.HREADYOUTS), 64'h0);
    checkOutput("sparse resp", 64'(bus2.HRESPS), 64'h1);
    checkOutput("sparse count", 64'(err_count2), 64'h1);
    checkOutput("full p1 rdata", 64'(bus.HRDATAS), 64'h11111111);
    tick();
    tick();
    checkOutput("sparse sel1 never", 64'(sel1_seen), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ahb_mtx_dec_param.md
Name: ahb_mtx_dec_param

Overview:
Parametrised AHB bus-matrix input-stage decoder for the L1 matrix.
- Maps each input-port transfer to one of NUM_PORTS output stages, or to an integrated default slave.
- Steers data-phase HREADYOUT, HRESP and HRDATA back from the selected output stage.
- New over the fixed-map decoders:
  - Parametrised region table and sparse-connectivity mask.
  - Defined (non-X) reset data-phase state.
  - Sticky capture of the first unmapped address, plus a saturating error counter for debug.

Parameters:
- NUM_PORTS, 4, number of output stages (1..8).
- ADDR_LO, 10, lowest decoded address bit; decode width DW = 32-ADDR_LO.
- REGION_BASE, all zeros, NUM_PORTS*DW packed inclusive lower bounds; port i occupies slice [i*DW +: DW].
- REGION_LIMIT, all zeros, NUM_PORTS*DW packed inclusive upper bounds.
- PORT_EN, all ones, NUM_PORTS-bit mask; a 0 bit means the port is unconnected and never selected.

Ports:
- HCLK  in  1  AHB clock.
- HRESETn  in  1  asynchronous active-low reset.
- HREADYS  in  1  input-stage HREADY (transfer done).
- sel_dec  in  1  HSEL from input stage.
- decode_addr_dec  in  DW  HADDR[31:ADDR_LO].
- trans_dec  in  2  HTRANS.
- active_i  in  NUM_PORTS  per-output-stage active flag.
- readyout_i  in  NUM_PORTS  per-output-stage HREADYOUT.
- resp_i  in  2*NUM_PORTS  per-output-stage HRESP.
- rdata_i  in  32*NUM_PORTS  per-output-stage HRDATA.
- err_clr  in  1  synchronous clear of the error capture.
- sel_o  out  NUM_PORTS  one-hot HSEL to the output stages.
- active_dec  out  1  active flag of the address-phase target.
- HREADYOUTS  out  1  data-phase ready.
- HRESPS  out  2  data-phase response (00 OKAY, 01 ERROR).
- HRDATAS  out  32  data-phase read data.
- err_valid_o  out  1  sticky flag: an unmapped access was captured.
- err_addr_o  out  DW  first captured unmapped address.
- err_count_o  out  8  saturating count of unmapped accesses.

Behaviour:
- Clock HCLK; reset HRESETn, asynchronous, active-low.
- Address decode (combinational), addr_port:
  - Port i hits when PORT_EN[i] and BASE_i <= addr <= LIMIT_i.
  - Lowest index wins on overlap.
  - Hold rule: if data_port==i and trans_dec==IDLE(00), addr_port=i regardless of address.
  - No hit and no hold: default slave (DFT).
- sel_o[i] = sel_dec & (addr_port==i). sel_dft = sel_dec & (addr_port==DFT).
- active_dec = active_i[addr_port]; forced to 1 when addr_port is DFT.
- Data-phase register data_port:
  - Encodings: NONE, 0..NUM_PORTS-1, DFT.
  - Reset value NONE.
  - Loads addr_port when HREADYS=1; otherwise holds.
  - The load is unconditional on sel_dec: an unselected address phase loads the decoded port.
- Data-phase mux:
  - data_port NONE: HREADYOUTS=1, HRESPS=00, HRDATAS=0.
  - data_port i: readyout_i[i], resp_i[2i+:2], rdata_i[32i+:32].
  - data_port DFT: default-slave ready/resp, HRDATAS=0.
- Default slave FSM, states IDLE/ERR1/ERR2, reset IDLE:
  - Accept condition acc = sel_dft & HREADYS & trans_dec[1].
  - IDLE: ready=1, resp=OKAY. acc -> ERR1.
  - ERR1: ready=0, resp=ERROR -> ERR2 unconditionally.
  - ERR2: ready=1, resp=ERROR. acc -> ERR1, else -> IDLE.
  - IDLE/BUSY to the default slave: OKAY, zero wait.
- Error capture, reset valid=0, addr=0, count=0:
  - On acc: count increments, saturating at 255.
  - On acc with valid=0: err_addr_o <= decode_addr_dec, valid <= 1.
  - err_clr alone: valid=0, count=0; address holds.
  - err_clr together with acc: valid=1, addr captured, count=1.
- Reset mid-transfer: all registers return to reset values immediately; outputs take NONE/IDLE values.

Test Plan:
- Config: NUM_PORTS=3, ADDR_LO=10.
  - Port0 0x080000-0x08003F (0x20000000-0x2000FFFF).
  - Port1 0x180000-0x27FFFF.
  - Port2 0x140000-0x17FFFF.
  - PORT_EN=3'b111.
- Reset release, idle bus -> sel_o=000, HREADYOUTS=1, HRESPS=00, HRDATAS=0, err_count_o=0.
- NONSEQ read 0x20000100, then IDLE, rdata_i port0=0xCAFEF00D -> sel_o=001 in address phase; next cycle HRDATAS=0xCAFEF00D.
- Hold rule: IDLE to 0x40000000 while data_port=1 -> sel_o=010, no default-slave activity.
- NONSEQ to 0x00000000 -> next cycle HREADYOUTS=0/HRESPS=01, then HREADYOUTS=1/HRESPS=01; err_addr_o=0x000000, err_valid_o=1, count=1.
- Two back-to-back unmapped NONSEQs (0x30000000, 0x30000400) -> ERR1,ERR2,ERR1,ERR2; err_addr_o stays 0x0C0000; count=2.
- 300 unmapped accesses -> count=255. err_clr asserted in the same cycle as an accept -> valid=1, count=1.
- PORT_EN=3'b101, NONSEQ 0x60000000 -> default-slave ERROR; sel_o[1] never asserted.
